// File: rtl/ew_threat_gen.sv
`default_nettype none
// ============================================================================
// Module   : ew_threat_gen
// Brief    : Plays JAM/SPOOF/NOISE/SAFE threat phases into ew_sim_top and
//            records the defence FSM's transitions and any fault.
// Revision : 1.0
// ============================================================================
module ew_threat_gen #(
   parameter int unsigned DWELL_W   = 8,
   parameter logic [7:0]  LFSR_SEED = 8'hB8,
   parameter logic [7:0]  JAM_SIG   = 8'd220
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [3:0]         scen_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [7:0]         spoof_val,
   input  logic [2:0]         fsm_state_in,
   input  logic               system_fault_in,
   output logic [7:0]         signal_out,
   output logic [7:0]         command_out,
   output logic [2:0]         phase,
   output logic               busy,
   output logic               done,
   output logic [7:0]         trans_count,
   output logic               fault_seen
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_JAM   = 3'd1,
      S_SPOOF = 3'd2,
      S_NOISE = 3'd3,
      S_SAFE  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [7:0]         c_seed      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [7:0]         c_cmd_jam   = 8'hFF;
   localparam logic [7:0]         c_cmd_noise = 8'hAA;
   localparam logic [7:0]         c_cnt_max   = 8'hFF;
   localparam logic [DWELL_W-1:0] c_dwell_one = DWELL_W'(1);

   state_t             state_q, state_d;
   logic [3:0]         mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [7:0]         spoof_q, spoof_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [7:0]         lfsr_q, lfsr_d;
   logic [2:0]         prev_fsm_q, prev_fsm_d;
   logic [7:0]         trans_q, trans_d;
   logic               fault_q, fault_d;
   logic [7:0]         sig_q, sig_d;
   logic [7:0]         cmd_q, cmd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               in_phase;
   logic               lfsr_fb;

   // Lowest enabled phase strictly after cur; DONE when none remain.
   function automatic state_t next_phase(input state_t cur, input logic [3:0] m);
      state_t nxt;
      nxt = S_DONE;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && ((i + 1) > int'(cur))) begin
            nxt = state_t'(3'(i + 1));
         end
      end
      return nxt;
   endfunction

   assign in_phase = (state_q != S_IDLE) && (state_q != S_DONE);
   assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      dwell_d    = dwell_q;
      spoof_d    = spoof_q;
      cnt_d      = cnt_q;
      trans_d    = trans_q;
      fault_d    = fault_q;
      prev_fsm_d = fsm_state_in;
      lfsr_d     = (state_q == S_NOISE) ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;

      if (in_phase && !abort) begin
         if ((fsm_state_in != prev_fsm_q) && (trans_q != c_cnt_max)) begin
            trans_d = trans_q + 8'd1;
         end
         if (system_fault_in) begin
            fault_d = 1'b1;
         end
      end

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mask_d  = scen_mask;
                  dwell_d = (dwell == '0) ? c_dwell_one : dwell;
                  spoof_d = spoof_val;
                  cnt_d   = '0;
                  lfsr_d  = c_seed;
                  trans_d = 8'd0;
                  fault_d = 1'b0;
                  state_d = next_phase(S_IDLE, scen_mask);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               if (cnt_q == (dwell_q - c_dwell_one)) begin
                  cnt_d   = '0;
                  state_d = next_phase(state_q, mask_q);
               end else begin
                  cnt_d = cnt_q + c_dwell_one;
               end
            end
         endcase
      end

      // Outputs are decoded from the next state so they register with it.
      sig_d  = 8'd0;
      cmd_d  = 8'd0;
      case (state_d)
         S_JAM: begin
            sig_d = JAM_SIG;
            cmd_d = c_cmd_jam;
         end
         S_SPOOF: begin
            sig_d = spoof_d;
         end
         S_NOISE: begin
            sig_d = lfsr_d;
            cmd_d = c_cmd_noise;
         end
         default: begin
            sig_d = 8'd0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         mask_q     <= 4'd0;
         dwell_q    <= '0;
         spoof_q    <= 8'd0;
         cnt_q      <= '0;
         lfsr_q     <= c_seed;
         prev_fsm_q <= 3'd0;
         trans_q    <= 8'd0;
         fault_q    <= 1'b0;
         sig_q      <= 8'd0;
         cmd_q      <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         dwell_q    <= dwell_d;
         spoof_q    <= spoof_d;
         cnt_q      <= cnt_d;
         lfsr_q     <= lfsr_d;
         prev_fsm_q <= prev_fsm_d;
         trans_q    <= trans_d;
         fault_q    <= fault_d;
         sig_q      <= sig_d;
         cmd_q      <= cmd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign signal_out  = sig_q;
   assign command_out = cmd_q;
   assign phase       = state_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign trans_count = trans_q;
   assign fault_seen  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ew_threat_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ew_threat_gen
// Brief    : Self-checking bench for ew_threat_gen (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_ew_threat_gen;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [3:0] scen_mask;
   logic [7:0] dwell, spoof_val;
   logic [2:0] fsm_state_in;
   logic       system_fault_in;
   logic [7:0] signal_out, command_out, trans_count;
   logic [2:0] phase;
   logic       busy, done, fault_seen;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] mask;
      logic [7:0] dw;
      logic [7:0] sp;
      int         run_len;
   } vec_t;

   typedef struct {
      logic [7:0] sig;
      logic [7:0] cmd;
      logic [2:0] ph;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   ew_threat_gen dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .abort           (abort),
      .scen_mask       (scen_mask),
      .dwell           (dwell),
      .spoof_val       (spoof_val),
      .fsm_state_in    (fsm_state_in),
      .system_fault_in (system_fault_in),
      .signal_out      (signal_out),
      .command_out     (command_out),
      .phase           (phase),
      .busy            (busy),
      .done            (done),
      .trans_count     (trans_count),
      .fault_seen      (fault_seen)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Expected per-cycle outputs of one run, starting right after the start edge.
   task automatic push_run(input vec_t v);
      logic [7:0] l;
      int         d;
      exp_t       e;
      l = 8'hB8;
      d = (v.dw == 8'd0) ? 1 : int'(v.dw);
      for (int p = 0; p < 4; p++) begin
         if (v.mask[p]) begin
            for (int c = 0; c < d; c++) begin
               e.ph   = 3'(p + 1);
               e.busy = 1'b1;
               e.done = 1'b0;
               case (p)
                  0:       begin e.sig = 8'd220; e.cmd = 8'hFF; end
                  1:       begin e.sig = v.sp;   e.cmd = 8'h00; end
                  2:       begin e.sig = l;      e.cmd = 8'hAA; l = lfsr_next(l); end
                  default: begin e.sig = 8'd0;   e.cmd = 8'h00; end
               endcase
               sb.push_back(e);
            end
         end
      end
      sb.push_back('{sig: 8'd0, cmd: 8'd0, ph: 3'd5, busy: 1'b1, done: 1'b1});
      sb.push_back('{sig: 8'd0, cmd: 8'd0, ph: 3'd0, busy: 1'b0, done: 1'b0});
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   busy_cycles;
      exp_t e;
      busy_cycles = 0;
      scen_mask   = v.mask;
      dwell       = v.dw;
      spoof_val   = v.sp;
      start       = 1'b1;
      push_run(v);
      step();
      // Scramble the programming inputs: the run must use the latched copies.
      start     = 1'b0;
      scen_mask = ~v.mask;
      dwell     = v.dw + 8'd5;
      spoof_val = ~v.sp;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("vec%0d sig/cmd/ph/busy/done", idx),
             {11'd0, signal_out, command_out, phase, busy, done},
             {11'd0, e.sig, e.cmd, e.ph, e.busy, e.done});
         if (busy) busy_cycles++;
         if (sb.size() > 0) step();
      end
      chk($sformatf("vec%0d busy_len", idx), busy_cycles, v.run_len);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{mask: 4'hF, dw: 8'd3, sp: 8'd123, run_len: 13};
      vecs[1] = '{mask: 4'h4, dw: 8'd4, sp: 8'd0,   run_len: 5};
      vecs[2] = '{mask: 4'h0, dw: 8'd5, sp: 8'd0,   run_len: 1};
      vecs[3] = '{mask: 4'h1, dw: 8'd0, sp: 8'd0,   run_len: 2};
      vecs[4] = '{mask: 4'hA, dw: 8'd2, sp: 8'd55,  run_len: 5};
      vecs[5] = '{mask: 4'h6, dw: 8'd1, sp: 8'd9,   run_len: 3};

      reset           = 1'b1;
      start           = 1'b1;
      abort           = 1'b0;
      scen_mask       = 4'hF;
      dwell           = 8'd3;
      spoof_val       = 8'd1;
      fsm_state_in    = 3'd0;
      system_fault_in = 1'b0;

      // Reset with start held high
      repeat (3) step();
      chk("rst outputs", {signal_out, command_out, phase, busy, done}, 32'd0);
      chk("rst counters", {trans_count, fault_seen}, 32'd0);
      reset = 1'b0;
      start = 1'b0;
      step();
      chk("idle after rst", {phase, busy, done}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], i);
      end

      // Response capture: 0->1->2->1 plus a fault pulse during JAM
      scen_mask = 4'h1;
      dwell     = 8'd8;
      step();
      start = 1'b1;
      step();
      start        = 1'b0;
      fsm_state_in = 3'd1;
      step();
      fsm_state_in = 3'd2;
      step();
      fsm_state_in    = 3'd1;
      system_fault_in = 1'b1;
      step();
      system_fault_in = 1'b0;
      for (int i = 0; i < 40 && done !== 1'b1; i++) step();
      chk("resp done seen", done, 1'b1);
      chk("resp trans_count", trans_count, 8'd3);
      chk("resp fault_seen", fault_seen, 1'b1);
      step();
      chk("resp busy low", busy, 1'b0);
      fsm_state_in = 3'd4;
      step();
      fsm_state_in = 3'd0;
      step();
      chk("resp hold trans", trans_count, 8'd3);
      chk("resp hold fault", fault_seen, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart clears trans", trans_count, 8'd0);
      chk("restart clears fault", fault_seen, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort to idle", phase, 3'd0);

      // Saturation: toggle the response every cycle over 400 in-phase cycles
      scen_mask = 4'h3;
      dwell     = 8'd200;
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 600 && done !== 1'b1; i++) begin
         fsm_state_in = fsm_state_in ^ 3'd1;
         step();
      end
      chk("sat done seen", done, 1'b1);
      chk("sat trans_count", trans_count, 8'd255);
      step();

      // Abort in SPOOF cycle 2, with start ignored while busy and during abort
      fsm_state_in = 3'd0;
      scen_mask    = 4'hF;
      dwell        = 8'd3;
      spoof_val    = 8'd7;
      step();
      start = 1'b1;
      step();
      chk("ab jam c1", phase, 3'd1);
      start        = 1'b0;
      fsm_state_in = 3'd1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("ab spoof c1 (busy start ignored)", {signal_out, phase}, {8'd7, 3'd2});
      step();
      chk("ab spoof c2", phase, 3'd2);
      abort = 1'b1;
      start = 1'b1;
      step();
      chk("ab outputs zero", {signal_out, command_out, phase, busy, done}, 32'd0);
      chk("ab trans hold", trans_count, 8'd1);
      abort = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ab no done/no restart", {phase, busy, done}, 32'd0);
      end

      // Reset mid-run
      start = 1'b1;
      step();
      start        = 1'b0;
      fsm_state_in = 3'd3;
      repeat (3) step();
      chk("mid-run counted", trans_count, 8'd1);
      reset = 1'b1;
      step();
      chk("mid rst outputs", {signal_out, command_out, phase, busy, done}, 32'd0);
      chk("mid rst counters", {trans_count, fault_seen}, 32'd0);
      reset = 1'b0;
      step();
      chk("mid rst stays idle", {phase, busy, done}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
